// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host receiver: synchronises, deframes and checks 11-bit frames, strips E0/F0
// prefixes and strobes one make/break scan code per key event.
module ps2_scan_rx #(
  parameter int unsigned SAMPLE_DIV    = 249,
  parameter int unsigned TIMEOUT_TICKS = 4000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       is_break,
  output logic       is_ext,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

  logic [1:0]      clk_sync_q, data_sync_q;
  logic            ps2_clk_s, ps2_data_s;
  logic [DivW-1:0] div_q;
  logic            tick, clk_prev_q, fall;

  state_e          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [10:0]     frame_q, frame_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic [7:0]      code_q, code_d;
  logic            is_break_q, is_break_d, is_ext_q, is_ext_d;
  logic            code_valid_q, code_valid_d, frame_err_q, frame_err_d;
  logic            frame_good;
  logic [7:0]      frame_byte;

  assign ps2_clk_s  = clk_sync_q[1];
  assign ps2_data_s = data_sync_q[1];
  assign tick       = (div_q == DivW'(SAMPLE_DIV - 1));
  assign fall       = tick & clk_prev_q & ~ps2_clk_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      div_q       <= '0;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      div_q       <= tick ? '0 : div_q + 1'b1;
      if (tick) clk_prev_q <= ps2_clk_s;
    end
  end

  // frame_q[0] = start, [8:1] = data, [9] = parity, [10] = stop once 11 bits are in.
  assign frame_byte = frame_q[8:1];
  assign frame_good = ~frame_q[0] & frame_q[10] & (^frame_q[9:1]);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    frame_d      = frame_q;
    to_cnt_d     = to_cnt_q;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;
    code_d       = code_q;
    is_break_d   = is_break_q;
    is_ext_d     = is_ext_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall && !ps2_data_s) begin
          frame_d   = {ps2_data_s, 10'b0};
          bit_cnt_d = 4'd1;
          to_cnt_d  = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (fall) begin
          frame_d   = {ps2_data_s, frame_q[10:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          to_cnt_d  = '0;
          if (bit_cnt_q == 4'd10) state_d = StCheck;
        end else if (tick) begin
          if (to_cnt_q == ToW'(TIMEOUT_TICKS - 1)) begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
            bit_cnt_d   = '0;
            to_cnt_d    = '0;
            state_d     = StIdle;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      StCheck: begin
        bit_cnt_d = '0;
        state_d   = StIdle;
        if (!frame_good) begin
          frame_err_d = 1'b1;
          ext_pend_d  = 1'b0;
          brk_pend_d  = 1'b0;
        end else if (frame_byte == 8'hE0) begin
          ext_pend_d = 1'b1;
        end else if (frame_byte == 8'hF0) begin
          brk_pend_d = 1'b1;
        end else begin
          code_valid_d = 1'b1;
          code_d       = frame_byte;
          is_break_d   = brk_pend_q;
          is_ext_d     = ext_pend_q;
          ext_pend_d   = 1'b0;
          brk_pend_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      frame_q      <= '0;
      to_cnt_q     <= '0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      code_q       <= '0;
      is_break_q   <= 1'b0;
      is_ext_q     <= 1'b0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_q      <= frame_d;
      to_cnt_q     <= to_cnt_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      code_q       <= code_d;
      is_break_q   <= is_break_d;
      is_ext_q     <= is_ext_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign code_valid = code_valid_q;
  assign code       = code_q;
  assign is_break   = is_break_q;
  assign is_ext     = is_ext_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: drives PS/2 frames and compares reported events against
// a prefix-tracking reference model of the keyboard byte stream.
module tb_ps2_scan_rx;
  localparam int unsigned SDIV = 5;
  localparam int unsigned TO   = 40;
  localparam int unsigned HALF = 60;  // ps2_clk half-period in clk cycles (12 ticks)

  logic       clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic       code_valid, is_break, is_ext, frame_err, busy;
  logic [7:0] code;

  ps2_scan_rx #(.SAMPLE_DIV(SDIV), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code_valid(code_valid), .code(code), .is_break(is_break), .is_ext(is_ext),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, stop_cyc = 0, last_lat = 0, both_cnt = 0, err_seen = 0, exp_err = 0, rd = 0;
  logic [9:0] got_q[$];  // {code, is_break, is_ext}
  logic [9:0] exp_q[$];
  bit m_ext = 0, m_brk = 0;
  logic [7:0] m_code = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (code_valid && frame_err) both_cnt++;
    if (code_valid || frame_err) last_lat = cyc - stop_cyc;
    if (code_valid) got_q.push_back({code, is_break, is_ext});
    if (frame_err) err_seen++;
  end

  task automatic send_bits(input logic [7:0] b, input bit flip, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // Reference model: keyboard byte-stream semantics.
  task automatic send_byte(input logic [7:0] b, input bit flip);
    send_bits(b, flip, 11);
    if (flip) begin
      m_ext = 0; m_brk = 0; exp_err++;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      exp_q.push_back({b, m_brk, m_ext});
      m_code = b; m_ext = 0; m_brk = 0;
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({code_valid, code, is_break, is_ext, frame_err, busy} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {code_valid, code, is_break, is_ext,
               frame_err, busy});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single();
    send_byte(8'h46, 0);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL single_count got %0d want %0d", got_q.size(), exp_q.size());
    end else if (got_q[rd] !== exp_q[rd]) begin
      errors++; $display("FAIL single_event got %h want %h", got_q[rd], exp_q[rd]);
    end
    rd = exp_q.size();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
    checks++;
    if (last_lat < 3 || last_lat > int'(SDIV) + 5) begin
      errors++; $display("FAIL single_latency got %0d want 3..%0d", last_lat, SDIV + 5);
    end
  endtask

  task automatic test_break();
    send_byte(8'hF0, 0);
    send_byte(8'h46, 0);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL break_count got %0d want %0d", got_q.size(), exp_q.size());
    end else if (got_q[rd] !== exp_q[rd]) begin
      errors++; $display("FAIL break_event got %h want %h", got_q[rd], exp_q[rd]);
    end
    rd = exp_q.size();
  endtask

  task automatic test_ext();
    send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
    send_byte(8'h16, 0);
    send_byte(8'hE0, 0); send_byte(8'hE0, 0); send_byte(8'h6B, 0);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL ext_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = rd; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL ext_event%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    rd = exp_q.size();
  endtask

  task automatic test_parity();
    send_byte(8'hF0, 0);
    send_byte(8'h1E, 1);
    checks++;
    if (err_seen !== exp_err) begin
      errors++; $display("FAIL parity_err got %0d want %0d", err_seen, exp_err);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL parity_nocode got %0d want %0d", got_q.size(), exp_q.size());
    end
    checks++;
    if (code !== m_code) begin errors++; $display("FAIL parity_hold got %h want %h", code, m_code); end
    checks++;
    if (both_cnt !== 0) begin errors++; $display("FAIL parity_overlap got %0d want 0", both_cnt); end
    send_byte(8'h1E, 0);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL parity_next_count got %0d want %0d", got_q.size(), exp_q.size());
    end else if (got_q[rd] !== exp_q[rd]) begin
      errors++; $display("FAIL parity_next got %h want %h", got_q[rd], exp_q[rd]);
    end
    rd = exp_q.size();
  endtask

  task automatic test_timeout();
    send_byte(8'hF0, 0);
    send_bits(8'h16, 0, 5);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_mid got %b want 1", busy); end
    repeat (TO * SDIV * 2) @(negedge clk);
    m_ext = 0; m_brk = 0; exp_err++;
    checks++;
    if (err_seen !== exp_err) begin
      errors++; $display("FAIL timeout_err got %0d want %0d", err_seen, exp_err);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_end got %b want 0", busy); end
    send_byte(8'h16, 0);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL timeout_next_count got %0d want %0d", got_q.size(), exp_q.size());
    end else if (got_q[rd] !== exp_q[rd]) begin
      errors++; $display("FAIL timeout_next got %h want %h", got_q[rd], exp_q[rd]);
    end
    rd = exp_q.size();
  endtask

  task automatic test_reset_mid();
    send_byte(8'hF0, 0);
    send_bits(8'h3C, 0, 7);
    @(negedge clk) rst_n = 1'b0;
    m_ext = 0; m_brk = 0; m_code = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({code_valid, code, is_break, is_ext, frame_err, busy} !== 13'b0) begin
      errors++;
      $display("FAIL midreset_outputs got %b want 0", {code_valid, code, is_break, is_ext,
               frame_err, busy});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (got_q.size() !== exp_q.size() || err_seen !== exp_err) begin
      errors++; $display("FAIL midreset_nostrobe got %0d/%0d want %0d/%0d", got_q.size(),
                         err_seen, exp_q.size(), exp_err);
    end
    send_byte(8'h3C, 0);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL midreset_next_count got %0d want %0d", got_q.size(), exp_q.size());
    end else if (got_q[rd] !== exp_q[rd]) begin
      errors++; $display("FAIL midreset_next got %h want %h", got_q[rd], exp_q[rd]);
    end
    rd = exp_q.size();
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    int r;
    for (int n = 0; n < 16; n++) begin
      r = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      if (r == 0) send_byte(8'hE0, 0);
      else if (r == 1) send_byte(8'hF0, 0);
      else if (r == 2) send_byte(b, 1);
      else send_byte(b, 0);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = rd; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL random_event%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    rd = exp_q.size();
    checks++;
    if (err_seen !== exp_err) begin
      errors++; $display("FAIL random_err got %0d want %0d", err_seen, exp_err);
    end
    checks++;
    if (both_cnt !== 0) begin errors++; $display("FAIL random_overlap got %0d want 0", both_cnt); end
    checks++;
    if (code !== m_code) begin errors++; $display("FAIL random_code got %h want %h", code, m_code); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_break();
    test_ext();
    test_parity();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
